// File: rtl/chunked_ripple_adder_if.sv
// Handshake bundle for chunked_ripple_adder.
// master: operand producer and result consumer; slave: the adder.
interface chunked_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_ripple_adder.sv
// Multi-cycle add/sub, one CHUNK-bit ripple slice per clock.
// Ports: clk, rst_n (async, active-low), bus (slave: valid/ready in/out).
module chunked_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    chunked_ripple_adder_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("chunked_ripple_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [KW-1:0]    k;
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK:0]   slice;
    logic             last;
    logic             accept;
    logic             in_ready;
    logic             out_valid;

    always_comb begin
        a_s   = a_q[int'(k)*CHUNK +: CHUNK];
        b_s   = b_q[int'(k)*CHUNK +: CHUNK];
        slice = {1'b0, a_s} + {1'b0, b_s} + (CHUNK+1)'(carry_q);
        last  = (k == KW'(N-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = in_ready && bus.in_valid;

    // b is stored pre-inverted for subtract; the +1 rides in the carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k       <= '0;
        end else begin
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b ^ {WIDTH{bus.sub}};
                carry_q <= bus.sub | bus.cin;
                k       <= '0;
            end
            if (state == RUN) begin
                sum_q[int'(k)*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
                carry_q <= slice[CHUNK];
                k       <= k + 1'b1;
                if (last) begin
                    cout_q <= slice[CHUNK];
                    ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (slice[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_ripple_adder.sv
// Directed bench for chunked_ripple_adder at CHUNK = 4, 16 and 1.
// Ports: none; drives three adder instances through their interfaces.
module tb_chunked_ripple_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   iv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         ordy;
    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [2:0]   co;
    logic [2:0]   of;
    logic [W-1:0] sm [3];
    bit           scr;
    int           n_cmp;
    int           n_bad;

    always #5 clk = ~clk;

    chunked_ripple_adder_if #(.WIDTH(W)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].in_valid  = iv[g];
        assign bus[g].a         = a;
        assign bus[g].b         = b;
        assign bus[g].cin       = cin;
        assign bus[g].sub       = sub;
        assign bus[g].out_ready = ordy;
        assign ov[g]            = bus[g].out_valid;
        assign ir[g]            = bus[g].in_ready;
        assign co[g]            = bus[g].cout;
        assign of[g]            = bus[g].ovf;
        assign sm[g]            = bus[g].sum;

        chunked_ripple_adder #(
            .WIDTH(W),
            .CHUNK(g == 0 ? 4 : (g == 1 ? 16 : 1))
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus[g])
        );
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (scr) begin
            a   = W'($urandom_range(0, 65535));
            b   = W'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
        end
    endtask

    // Status word: {out_valid, in_ready, cout, ovf, sum}
    function automatic logic [31:0] stat(int s);
        return 32'({ov[s], ir[s], co[s], of[s], sm[s]});
    endfunction

    task automatic start(int s, logic [W-1:0] x, logic [W-1:0] y,
                         logic ci, logic sb, string tag);
        chk({tag, ":rdy"}, 32'(ir[s]), 32'd1);
        a     = x;
        b     = y;
        cin   = ci;
        sub   = sb;
        iv[s] = 1'b1;
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        chk({tag, ":busy"}, 32'(ir[s]), 32'd0);
    endtask

    task automatic finish_op(int s, int n, logic [W-1:0] es, logic ec,
                             logic eo, string tag, bit rel);
        int cnt = 0;
        while (!ov[s] && cnt < n + 4) begin
            tick();
            cnt++;
        end
        chk({tag, ":lat"}, 32'(cnt), 32'(n));
        chk({tag, ":sum"}, 32'(sm[s]), 32'(es));
        chk({tag, ":cout"}, 32'(co[s]), 32'(ec));
        chk({tag, ":ovf"}, 32'(of[s]), 32'(eo));
        if (rel) begin
            ordy = 1'b1;
            tick();
            ordy = 1'b0;
            chk({tag, ":rel"}, 32'({ov[s], ir[s]}), 32'b01);
        end
    endtask

    task automatic pulse_reset(int s, string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ":rst"}, stat(s), 32'h4_0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        iv    = '0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        ordy  = 1'b0;
        scr   = 1'b1;

        #12;
        for (int s = 0; s < 3; s++) chk("reset", stat(s), 32'h4_0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        start(0, 16'h1234, 16'h0FED, 1'b1, 1'b0, "c4_add");
        finish_op(0, 4, 16'h2222, 1'b0, 1'b0, "c4_add", 1'b1);
        start(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "c4_wrap");
        finish_op(0, 4, 16'h0000, 1'b1, 1'b0, "c4_wrap", 1'b1);
        start(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "c4_povf");
        finish_op(0, 4, 16'h8000, 1'b0, 1'b1, "c4_povf", 1'b1);
        start(0, 16'h0005, 16'h0007, 1'b1, 1'b1, "c4_sub");
        finish_op(0, 4, 16'hFFFE, 1'b0, 1'b0, "c4_sub", 1'b1);
        start(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "c4_novf");
        finish_op(0, 4, 16'h7FFF, 1'b1, 1'b1, "c4_novf", 1'b1);
        start(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "c4_rip");
        finish_op(0, 4, 16'h0100, 1'b0, 1'b0, "c4_rip", 1'b1);

        start(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "c16_wrap");
        finish_op(1, 1, 16'h0000, 1'b1, 1'b0, "c16_wrap", 1'b1);
        start(1, 16'h0005, 16'h0007, 1'b1, 1'b1, "c16_sub");
        finish_op(1, 1, 16'hFFFE, 1'b0, 1'b0, "c16_sub", 1'b1);
        start(2, 16'h1234, 16'h0FED, 1'b1, 1'b0, "c1_add");
        finish_op(2, 16, 16'h2222, 1'b0, 1'b0, "c1_add", 1'b1);
        start(2, 16'h8000, 16'h0001, 1'b0, 1'b1, "c1_novf");
        finish_op(2, 16, 16'h7FFF, 1'b1, 1'b1, "c1_novf", 1'b1);

        start(0, 16'hABCD, 16'h1111, 1'b0, 1'b0, "bp");
        finish_op(0, 4, 16'hBCDE, 1'b0, 1'b0, "bp", 1'b0);
        scr   = 1'b0;
        a     = 16'h0001;
        b     = 16'h0002;
        cin   = 1'b0;
        sub   = 1'b0;
        iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", stat(0), 32'h8_BCDE);
        end
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("bp_rel", 32'({ov[0], ir[0]}), 32'b01);
        tick();
        iv[0] = 1'b0;
        chk("b2b_acc", 32'(ir[0]), 32'd0);
        finish_op(0, 4, 16'h0003, 1'b0, 1'b0, "b2b", 1'b1);
        scr = 1'b1;

        start(0, 16'h1234, 16'h1111, 1'b0, 1'b0, "c4_abort");
        tick();
        tick();
        pulse_reset(0, "c4_abort");
        start(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "c4_post");
        finish_op(0, 4, 16'h0100, 1'b0, 1'b0, "c4_post", 1'b1);

        start(1, 16'h1234, 16'h0FED, 1'b1, 1'b0, "c16_abort");
        tick();
        chk("c16_done", 32'(ov[1]), 32'd1);
        pulse_reset(1, "c16_abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c16_noval", 32'(ov[1]), 32'd0);
        end
        start(1, 16'h8000, 16'h0001, 1'b0, 1'b1, "c16_post");
        finish_op(1, 1, 16'h7FFF, 1'b1, 1'b1, "c16_post", 1'b1);

        start(2, 16'h1234, 16'h0FED, 1'b1, 1'b0, "c1_abort");
        tick();
        tick();
        pulse_reset(2, "c1_abort");
        start(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "c1_post");
        finish_op(2, 16, 16'h8000, 1'b0, 1'b1, "c1_post", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
